// File: rtl/freq_shift_pkg.sv
// Shared types and defaults for the frequency-shift sequencer.
package freq_shift_pkg;

    localparam int N_SAMPLES_DEF = 1024;
    localparam int DW_DEF        = 16;
    localparam int IDX_W_DEF     = 11;
    localparam int DP_LAT_DEF    = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_0 = 2'b00,
        OP_1 = 2'b01,
        OP_2 = 2'b10,
        OP_3 = 2'b11
    } op_t;

endpackage

// File: rtl/freq_shift_ctrl_if.sv
// Downstream result stream: single-beat ready/valid carrying sin, cos and sample index.
interface freq_shift_ctrl_if
    import freq_shift_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int IDX_W = IDX_W_DEF
);
    logic                    out_valid;
    logic                    out_ready;
    logic signed [DW-1:0]    out_sin;
    logic signed [DW-1:0]    out_cos;
    logic        [IDX_W-1:0] out_idx;

    modport master (output out_valid, out_sin, out_cos, out_idx, input out_ready);
    modport slave  (input out_valid, out_sin, out_cos, out_idx, output out_ready);
endinterface

// File: rtl/freq_shift_out_reg.sv
// Single-entry output holding register: capture a result, hold it until accepted, drop it on flush.
module freq_shift_out_reg
    import freq_shift_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int IDX_W = IDX_W_DEF
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    capture,
    input  logic                    flush,
    input  logic signed [DW-1:0]    sin_in,
    input  logic signed [DW-1:0]    cos_in,
    input  logic        [IDX_W-1:0] idx_in,
    freq_shift_ctrl_if.master       bus
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_sin   <= '0;
            bus.out_cos   <= '0;
            bus.out_idx   <= '0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
        end else if (capture) begin
            bus.out_valid <= 1'b1;
            bus.out_sin   <= sin_in;
            bus.out_cos   <= cos_in;
            bus.out_idx   <= idx_in;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/freq_shift_ctrl.sv
// Frame sequencer for the sin/cos rotator: fetch, load, wait out latency, emit.
// Define FREQ_SHIFT_CTRL_STATS_EN to add the emit_cnt / drop_cnt statistics outputs.
module freq_shift_ctrl
    import freq_shift_pkg::*;
#(
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int DW        = DW_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int DP_LAT    = DP_LAT_DEF
)(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic        [1:0]                op_cfg,
    input  logic                             abort,
    output logic                             busy,
    output logic                             done,
    output logic                             rd_en,
    output logic        [$clog2(N_SAMPLES)-1:0] rd_addr,
    input  logic signed [DW-1:0]             rd_sin,
    input  logic signed [DW-1:0]             rd_cos,
    output logic signed [DW-1:0]             dp_sinx,
    output logic signed [DW-1:0]             dp_cosx,
    output logic        [1:0]                dp_op,
    output logic        [IDX_W-1:0]          dp_i,
    input  logic                             dp_valid,
    input  logic signed [DW-1:0]             dp_sin_out,
    input  logic signed [DW-1:0]             dp_cos_out,
    freq_shift_ctrl_if.master                out_bus
`ifdef FREQ_SHIFT_CTRL_STATS_EN
    ,
    output logic        [IDX_W:0]            emit_cnt,
    output logic        [IDX_W:0]            drop_cnt
`endif
);

    localparam int AW    = $clog2(N_SAMPLES);
    localparam int CNT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    op_t                op_reg;
    logic [CNT_W-1:0]   wait_cnt;
    logic               capture, drop, advance, flush, emitted;
    logic               last, handshake, accept_start;

    assign busy         = state inside {S_FETCH, S_LOAD, S_WAIT, S_EMIT};
    assign done         = (state == S_DONE);
    assign rd_en        = (state == S_FETCH);
    assign rd_addr      = idx[AW-1:0];
    assign last         = (idx == IDX_W'(N_SAMPLES - 1));
    assign handshake    = out_bus.out_valid && out_bus.out_ready;
    assign accept_start = (state == S_IDLE) && start;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        drop      = 1'b0;
        advance   = 1'b0;
        flush     = 1'b0;
        emitted   = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    if (dp_valid) begin
                        capture   = 1'b1;
                        state_nxt = S_EMIT;
                    end else begin
                        drop    = 1'b1;
                        advance = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (handshake) begin
                    advance = 1'b1;
                    emitted = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (advance) state_nxt = last ? S_DONE : S_FETCH;

        // Abort overrides everything inside a frame; the pending result is discarded.
        if (abort && busy) begin
            state_nxt = S_DONE;
            capture   = 1'b0;
            drop      = 1'b0;
            advance   = 1'b0;
            emitted   = 1'b0;
            flush     = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            op_reg   <= OP_0;
            wait_cnt <= '0;
            dp_sinx  <= '0;
            dp_cosx  <= '0;
            dp_op    <= '0;
            dp_i     <= '0;
        end else begin
            state <= state_nxt;

            if (accept_start) begin
                idx    <= '0;
                op_reg <= op_t'(op_cfg);
            end else if (advance && !last) begin
                idx <= idx + IDX_W'(1);
            end

            // dp_* only change here, so they stay stable for the whole datapath latency.
            if (state == S_LOAD) begin
                dp_sinx  <= rd_sin;
                dp_cosx  <= rd_cos;
                dp_op    <= op_reg;
                dp_i     <= idx;
                wait_cnt <= CNT_W'(DP_LAT - 1);
            end else if (state == S_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
        end
    end

    freq_shift_out_reg #(
        .DW    (DW),
        .IDX_W (IDX_W)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (capture),
        .flush   (flush),
        .sin_in  (dp_sin_out),
        .cos_in  (dp_cos_out),
        .idx_in  (idx),
        .bus     (out_bus)
    );

`ifdef FREQ_SHIFT_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            emit_cnt <= '0;
            drop_cnt <= '0;
        end else if (accept_start) begin
            emit_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (emitted) emit_cnt <= emit_cnt + (IDX_W+1)'(1);
            if (drop)    drop_cnt <= drop_cnt + (IDX_W+1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_freq_shift_ctrl.sv
// Self-checking bench for freq_shift_ctrl: memory and datapath models plus a result scoreboard.
module tb_freq_shift_ctrl;

    localparam int N     = 1024;
    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int IDX_W = 11;

    typedef logic [IDX_W+2*DW-1:0] res_t;

    logic                    clk, rst_n, start, abort;
    logic        [1:0]       op_cfg;
    logic                    busy, done, rd_en;
    logic        [AW-1:0]    rd_addr;
    logic signed [DW-1:0]    rd_sin, rd_cos;
    logic signed [DW-1:0]    dp_sinx, dp_cosx;
    logic        [1:0]       dp_op;
    logic        [IDX_W-1:0] dp_i;
    logic                    dp_valid;
    logic signed [DW-1:0]    dp_sin_out, dp_cos_out;
`ifdef FREQ_SHIFT_CTRL_STATS_EN
    logic        [IDX_W:0]   emit_cnt, drop_cnt;
`endif

    freq_shift_ctrl_if bus ();

    freq_shift_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_cfg     (op_cfg),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_sin     (rd_sin),
        .rd_cos     (rd_cos),
        .dp_sinx    (dp_sinx),
        .dp_cosx    (dp_cosx),
        .dp_op      (dp_op),
        .dp_i       (dp_i),
        .dp_valid   (dp_valid),
        .dp_sin_out (dp_sin_out),
        .dp_cos_out (dp_cos_out),
        .out_bus    (bus)
`ifdef FREQ_SHIFT_CTRL_STATS_EN
        ,
        .emit_cnt   (emit_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    logic signed [DW-1:0] mem_sin [N];
    logic signed [DW-1:0] mem_cos [N];
    bit                   drop_mask [N];
    res_t                 exp_q [$];

    int   n_checks = 0, n_errors = 0;
    int   cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;
    int   results = 0, frame_total = 0;
    int   stall_idx = -1, stall_left = 0;
    bit   rnd_ready = 1'b0;
    bit   held = 1'b0;
    res_t held_val;
    logic [1:0] frame_op = 2'b00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Sample memory: data appears the cycle after the read strobe, garbage otherwise.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_sin <= mem_sin[rd_addr];
            rd_cos <= mem_cos[rd_addr];
        end else begin
            rd_sin <= DW'($urandom);
            rd_cos <= DW'($urandom);
        end
    end

    // Datapath stand-in: inputs are stable across the latency, so a combinational model suffices.
    assign dp_valid   = !drop_mask[dp_i[AW-1:0]];
    assign dp_sin_out = dp_sinx + DW'(dp_op);
    assign dp_cos_out = dp_cosx - DW'(dp_i);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic res_t exp_result(input int k, input logic [1:0] op);
        logic signed [DW-1:0] s, c;
        s = mem_sin[k] + DW'(op);
        c = mem_cos[k] - DW'(k);
        return {IDX_W'(k), s, c};
    endfunction

    // Consumer: drives out_ready, scoreboards accepted results, checks stability under stall.
    always @(negedge clk) begin
        if (done) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
        end
        if (held && bus.out_valid)
            check("hold_stable", {bus.out_idx, bus.out_sin, bus.out_cos}, held_val);
        held = 1'b0;

        if (bus.out_valid && int'(bus.out_idx) == stall_idx && stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
        end else begin
            bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end

        if (bus.out_valid) begin
            if (bus.out_ready) begin
                results++;
                check("dp_op", dp_op, frame_op);
                if (exp_q.size() == 0)
                    check("extra_result", results, frame_total);
                else
                    check("result", {bus.out_idx, bus.out_sin, bus.out_cos}, exp_q.pop_front());
            end else begin
                held     = 1'b1;
                held_val = {bus.out_idx, bus.out_sin, bus.out_cos};
                check("stall_no_fetch", rd_en, 1'b0);
            end
        end
    end

    task automatic start_frame(input logic [1:0] op);
        exp_q.delete();
        for (int k = 0; k < N; k++)
            if (!drop_mask[k]) exp_q.push_back(exp_result(k, op));
        frame_total = exp_q.size();
        frame_op    = op;
        results     = 0;
        done_cnt    = 0;
        @(negedge clk);
        start     = 1'b1;
        op_cfg    = op;
        start_cyc = cyc;
        @(negedge clk);
        start  = 1'b0;
        op_cfg = 2'($urandom);
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic run_until_done(input int budget, input int busy_start_idx, input int abort_idx);
        int n = 0;
        bit abort_pending = 1'b0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            abort = 1'b0;
            if (abort_pending) begin
                check("abort_valid_low", bus.out_valid, 1'b0);
                check("abort_done", done, 1'b1);
                check("abort_busy", busy, 1'b0);
                abort_pending = 1'b0;
            end else if (abort_idx >= 0 && bus.out_valid && int'(bus.out_idx) == abort_idx) begin
                abort         = 1'b1;
                abort_pending = 1'b1;
                abort_idx     = -1;
            end
            if (busy_start_idx >= 0 && busy && int'(dp_i) == busy_start_idx) begin
                start          = 1'b1;
                op_cfg         = 2'b00;
                busy_start_idx = -1;
            end
        end
        check("done_in_budget", n < budget, 1'b1);
        start = 1'b0;
        abort = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_frame_checks(input int exp_results);
        check("result_count", results, exp_results);
        check("queue_empty", exp_q.size(), 0);
        check("done_once", done_cnt, 1);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        logic [1:0] op;
        for (int k = 0; k < N; k++) begin
            mem_sin[k]   = DW'(k);
            mem_cos[k]   = DW'($urandom);
            drop_mask[k] = 1'b0;
        end
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        op_cfg = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset_ctrl", {busy, done, rd_en, rd_addr, dp_op, dp_i, bus.out_valid, bus.out_idx}, '0);
            check("reset_data", {dp_sinx, dp_cosx, bus.out_sin, bus.out_cos}, '0);
        end
`ifdef FREQ_SHIFT_CTRL_STATS_EN
        check("reset_stats", {emit_cnt, drop_cnt}, '0);
`endif

        // Full frame, no backpressure: exact frame length.
        rnd_ready = 1'b0;
        start_frame(2'b11);
        run_until_done(6000, -1, -1);
        check("frame_cycles", done_cyc - start_cyc, 5 * N + 1);
        end_frame_checks(N);

        // Backpressure at idx 5, drops at 10..12, random ready, ignored start at idx 50.
        for (int k = 10; k <= 12; k++) drop_mask[k] = 1'b1;
        rnd_ready  = 1'b1;
        stall_idx  = 5;
        stall_left = 7;
        op = 2'($urandom_range(1, 3));
        start_frame(op);
        run_until_done(20000, 50, -1);
        end_frame_checks(N - 3);
        check("stall_applied", stall_left, 0);
`ifdef FREQ_SHIFT_CTRL_STATS_EN
        check("stats_emit", emit_cnt, N - 3);
        check("stats_drop", drop_cnt, 3);
`endif
        for (int k = 10; k <= 12; k++) drop_mask[k] = 1'b0;

        // Abort while result 100 is stalled in EMIT.
        rnd_ready  = 1'b0;
        stall_idx  = 100;
        stall_left = 1000;
        start_frame(2'($urandom_range(0, 3)));
        run_until_done(20000, -1, 100);
        check("abort_results", results, 100);
        check("abort_done_once", done_cnt, 1);
        check("abort_idle", busy, 1'b0);
`ifdef FREQ_SHIFT_CTRL_STATS_EN
        check("abort_stats", {emit_cnt, drop_cnt}, {12'd100, 12'd0});
`endif
        exp_q.delete();
        stall_idx  = -1;
        stall_left = 0;

        // Restart after abort with a new op, random ready.
        rnd_ready = 1'b1;
        start_frame(2'b01);
        run_until_done(20000, -1, -1);
        end_frame_checks(N);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/freq_shift_ctrl.md
Name: freq_shift_ctrl

Overview:
Sequencer for the frequency-shift datapath (sin/cos rotator with op and sample index inputs). It walks a 1024-entry sin/cos sample memory and presents each sample with its index and the frame's op to the datapath. It waits out the datapath latency, then hands each valid result to a downstream consumer with a ready/valid handshake. A start/busy/done interface sits toward the system controller.

Parameters:
N_SAMPLES, 1024, samples per frame (power of two)
DW, 16, signed sample width
IDX_W, 11, datapath index width (must hold N_SAMPLES)
DP_LAT, 2, datapath latency in clocks from inputs stable to result sampled

Ports:
Clock  in  1  rising-edge clock
Reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to run a frame; ignored while busy
op_cfg  in  2  op for the frame, captured on accepted start
abort  in  1  terminate the current frame
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame end (normal or abort)
rd_en  out  1  sample memory read strobe
rd_addr  out  log2(N_SAMPLES)  sample memory address
rd_sin  in  DW  memory sin data, valid the cycle after rd_en
rd_cos  in  DW  memory cos data, valid the cycle after rd_en
dp_sinx  out  DW  datapath sin input (registered)
dp_cosx  out  DW  datapath cos input (registered)
dp_op  out  2  datapath op (registered)
dp_i  out  IDX_W  datapath sample index (registered)
dp_valid  in  1  datapath result valid
dp_sin_out  in  DW  datapath sin result
dp_cos_out  in  DW  datapath cos result
out_valid  out  1  result available downstream
out_ready  in  1  downstream accepts
out_sin  out  DW  captured sin result
out_cos  out  DW  captured cos result
out_idx  out  IDX_W  index of the result

Behaviour:
- Reset: state IDLE; every output 0 (including busy, done, rd_en, rd_addr, dp_*, out_*); index counter 0; op register 0.
- FSM states: IDLE, FETCH, LOAD, WAIT, EMIT, DONE.
- IDLE: start=1 -> capture op_cfg, idx=0, busy=1, go to FETCH.
- FETCH: rd_en=1, rd_addr=idx[log2(N)-1:0]; next state LOAD.
- LOAD: register rd_sin/rd_cos into dp_sinx/dp_cosx; dp_i=idx; dp_op=op register. Load the wait counter with DP_LAT-1; next state WAIT.
- WAIT: count down. At 0, sample dp_valid:
  - dp_valid=1: capture results and idx into out_*, set out_valid=1, go to EMIT.
  - dp_valid=0: drop the sample and advance.
- EMIT: hold out_* stable while out_valid=1 and out_ready=0. When out_valid and out_ready are both 1, clear out_valid next cycle and advance.
- Advance: if idx==N_SAMPLES-1 go to DONE, else idx+1 and go to FETCH. idx never wraps within a frame.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- Per-sample cost: 2+DP_LAT cycles when dropped; 3+DP_LAT cycles with out_ready held high.
- dp_* inputs stay constant from LOAD until the next LOAD.
- start while busy: ignored; op_cfg changes mid-frame have no effect.
- abort (any non-IDLE state except DONE): next state DONE and out_valid cleared, even mid-handshake. The pending result is discarded, idx is not incremented, and done pulses once.
- abort and start both high in IDLE: start wins; abort is ignored in IDLE.
- Reset_n low mid-frame: immediate return to reset values, no done pulse.

Optional Feature:
FREQ_SHIFT_CTRL_STATS_EN:
- Defined: adds outputs emit_cnt (IDX_W+1) and drop_cnt (IDX_W+1). They count handshaken results and dp_valid=0 drops, are cleared on accepted start, hold after DONE, and are 0 on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package freq_shift_pkg holds:
  - state encoding typedef (3-bit, IDLE=0)
  - op codes OP_0..OP_3 (2'b00..2'b11)
  - DW and IDX_W defaults
- One sub-module, freq_shift_out_reg: a single-entry ready/valid output holding register (capture, hold, clear-on-abort).

Test Plan:
- Reset: Reset_n=0 then 1 with start=0 -> all outputs 0, busy=0 for 20 cycles.
- Full frame: op_cfg=2'b11, dp_valid always 1, out_ready=1, memory[k]=k -> 1024 results with out_idx 0..1023 in order. done pulses exactly once at cycle 5*1024+1 after start, and dp_op=3 throughout.
- Backpressure: out_ready low for 7 cycles at idx 5 -> out_sin/out_cos/out_idx stable for 7 cycles; idx 6 not fetched until the handshake; no loss or duplication.
- Drop: dp_valid=0 for idx 10..12 -> no out_valid for those indices; 1021 results emitted (drop_cnt=3 with the macro defined).
- Abort: abort at idx 100 during EMIT -> out_valid falls next cycle, done pulses once, busy=0; a new start with op_cfg=2'b01 restarts from idx 0 with dp_op=1.
- Start while busy: start pulse at idx 50 with op_cfg=2'b00 -> ignored, frame completes with the original op, exactly one done.
